// File: rtl/sram2sramlike_bridge_if.sv
// sram2sramlike_bridge_if
//   SRAM-like bus between the bridge and the AXI-side converter.
//   The master (bridge) drives req/wr/size/addr/wdata.
//   The slave drives rdata/addr_ok/data_ok.
//
//   Handshake: a request is accepted in any cycle where req and addr_ok are
//   both high. Once raised, req stays high with stable wr/size/addr/wdata
//   until it is accepted or the access is flushed. Every accepted request
//   later gets exactly one data_ok pulse, and responses come back in
//   request order.
interface sram2sramlike_bridge_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram2sramlike_bridge.sv
// sram2sramlike_bridge
//   Turns a single-cycle SRAM-style pipeline access into an SRAM-like
//   addr_ok/data_ok transaction. The pipeline is stalled until the data
//   returns. The completed result is held while the pipeline is frozen by
//   another source. A flush cancels the access in flight, and any response
//   still owed for it is counted and dropped when it arrives.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   sram_en         pipeline access request, held until stall drops
//   sram_addr       byte address
//   sram_wen        byte write strobes (0 = read)
//   sram_wdata      lane-aligned write data
//   sram_rdata      read result (registered)
//   stall           pipeline must stall
//   longest_stall   pipeline frozen by another source
//   flush           cancel current access
//   bus             SRAM-like master side (req/wr/size/addr/wdata/
//                   rdata/addr_ok/data_ok)
//   dbg_state       current FSM state (IDLE=0, ADDR=1, DATA=2, DONE=3)
module sram2sramlike_bridge #(
    parameter int MAX_PEND    = 4,
    parameter int WRITE_EN    = 1,
    parameter int RDATA_CLEAR = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sram_en,
    input  logic [31:0]                   sram_addr,
    input  logic [3:0]                    sram_wen,
    input  logic [31:0]                   sram_wdata,
    output logic [31:0]                   sram_rdata,
    output logic                          stall,
    input  logic                          longest_stall,
    input  logic                          flush,
    sram2sramlike_bridge_if.master        bus,
    output logic [1:0]                    dbg_state
);

    localparam int DW = $clog2(MAX_PEND + 1);
    localparam logic [DW-1:0] MAX_PEND_C = DW'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] disc_q, disc_d;
    logic [31:0]   rdata_q, rdata_d;

    logic        req;
    logic        is_write;
    logic        drain;
    logic        capture;
    logic [1:0]  size;
    logic [1:0]  offset;

    // The low address bits are rebuilt from the strobes, so the incoming
    // ones are not needed.
    logic unused_addr_lo;
    assign unused_addr_lo = ^sram_addr[1:0];

    // The request is dropped during reset, while flushing, and while the
    // discard counter is full. A full counter means the bus cannot accept
    // another outstanding response.
    assign req = sram_en & ~rst & ~flush
               & ((state_q == IDLE) | (state_q == ADDR))
               & (disc_q < MAX_PEND_C);

    assign is_write = (WRITE_EN != 0) && (sram_wen != 4'b0000);

    // A late response owed to a cancelled access is consumed here, whatever
    // state the FSM is in.
    assign drain = bus.data_ok & (disc_q != '0);

    // A response completes the live access only when nothing older is owed
    // and the access is not being cancelled in the same cycle.
    assign capture = (state_q == DATA) & bus.data_ok & (disc_q == '0) & ~flush;

    // Byte-accurate size and offset for writes. Reads always fetch the
    // aligned word. An illegal strobe mix falls back to a word access.
    always_comb begin
        size   = 2'd2;
        offset = 2'd0;
        if (is_write) begin
            case (sram_wen)
                4'b1111: begin size = 2'd2; offset = 2'd0; end
                4'b0011: begin size = 2'd1; offset = 2'd0; end
                4'b1100: begin size = 2'd1; offset = 2'd2; end
                4'b0001: begin size = 2'd0; offset = 2'd0; end
                4'b0010: begin size = 2'd0; offset = 2'd1; end
                4'b0100: begin size = 2'd0; offset = 2'd2; end
                4'b1000: begin size = 2'd0; offset = 2'd3; end
                default: begin size = 2'd2; offset = 2'd0; end
            endcase
        end
    end

    assign bus.req   = req;
    assign bus.wr    = is_write;
    assign bus.size  = size;
    assign bus.addr  = {sram_addr[31:2], offset};
    assign bus.wdata = (WRITE_EN != 0) ? sram_wdata : 32'h0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ADDR: begin
                if (req && bus.addr_ok) state_d = DATA;
                else if (req)           state_d = ADDR;
                else                    state_d = IDLE;
            end
            DATA: begin
                if (flush)        state_d = IDLE;
                else if (capture) state_d = DONE;
            end
            DONE: begin
                if (flush || !longest_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flushing in DATA leaves one response owed, unless that response is
    // arriving right now with nothing older outstanding. In that case it is
    // simply dropped. When an older response drains in the same cycle, the
    // +1 and the -1 cancel.
    always_comb begin
        disc_d = disc_q;
        if (flush && (state_q == DATA) && !(bus.data_ok && (disc_q == '0))) begin
            if (!drain) disc_d = disc_q + DW'(1);
        end else if (drain) begin
            disc_d = disc_q - DW'(1);
        end
    end

    always_comb begin
        if (capture)              rdata_d = bus.rdata;
        else if (RDATA_CLEAR != 0) rdata_d = 32'h0;
        else                      rdata_d = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            disc_q  <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall      = sram_en & (state_q != DONE) & ~flush;
    assign sram_rdata = rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram2sramlike_bridge.sv
module tb_sram2sramlike_bridge;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults (MAX_PEND=4, WRITE_EN=1, RDATA_CLEAR=0)
  logic        a_en, a_lstall, a_flush, a_stall;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wen;
  logic [1:0]  a_dbg;
  sram2sramlike_bridge_if bus_a();

  sram2sramlike_bridge #(.MAX_PEND(4), .WRITE_EN(1), .RDATA_CLEAR(0)) dut_a (
    .clk(clk), .rst(rst), .sram_en(a_en), .sram_addr(a_addr), .sram_wen(a_wen),
    .sram_wdata(a_wdata), .sram_rdata(a_rdata), .stall(a_stall),
    .longest_stall(a_lstall), .flush(a_flush), .bus(bus_a), .dbg_state(a_dbg)
  );

  // ---------------- DUT B: MAX_PEND=2, read-only, clearing read data
  logic        b_en, b_lstall, b_flush, b_stall;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_wen;
  logic [1:0]  b_dbg;
  sram2sramlike_bridge_if bus_b();

  sram2sramlike_bridge #(.MAX_PEND(2), .WRITE_EN(0), .RDATA_CLEAR(1)) dut_b (
    .clk(clk), .rst(rst), .sram_en(b_en), .sram_addr(b_addr), .sram_wen(b_wen),
    .sram_wdata(b_wdata), .sram_rdata(b_rdata), .stall(b_stall),
    .longest_stall(b_lstall), .flush(b_flush), .bus(bus_b), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [66:0] exp_bus_a[$];   // {wr, size, addr, wdata}
  logic [66:0] exp_bus_b[$];
  logic [31:0] exp_rd_a[$];
  logic [31:0] exp_rd_b[$];

  task automatic chk(input string name, input logic [66:0] got, input logic [66:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: pops an expected bus request on every handshake, and an
  // expected read result whenever an access completes (stall falls while
  // the pipeline still requests and no flush is active).
  logic        a_prev_stall = 1'b0;
  logic        b_prev_stall = 1'b0;
  logic [66:0] mon_e;
  logic [31:0] mon_r;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.req && bus_a.addr_ok) begin
        if (exp_bus_a.size() == 0) chk("a_bus_unexpected_req", {bus_a.wr, bus_a.size, bus_a.addr, bus_a.wdata}, '0);
        else begin
          mon_e = exp_bus_a.pop_front();
          chk("a_bus_req", {bus_a.wr, bus_a.size, bus_a.addr, bus_a.wdata}, mon_e);
        end
      end
      if (a_en && !a_stall && !a_flush && a_prev_stall) begin
        if (exp_rd_a.size() == 0) chk("a_rd_unexpected", 67'(a_rdata), '1);
        else begin
          mon_r = exp_rd_a.pop_front();
          chk("a_rdata", 67'(a_rdata), 67'(mon_r));
        end
      end
      a_prev_stall = a_stall;

      if (bus_b.req && bus_b.addr_ok) begin
        if (exp_bus_b.size() == 0) chk("b_bus_unexpected_req", {bus_b.wr, bus_b.size, bus_b.addr, bus_b.wdata}, '0);
        else begin
          mon_e = exp_bus_b.pop_front();
          chk("b_bus_req", {bus_b.wr, bus_b.size, bus_b.addr, bus_b.wdata}, mon_e);
        end
      end
      if (b_en && !b_stall && !b_flush && b_prev_stall) begin
        if (exp_rd_b.size() == 0) chk("b_rd_unexpected", 67'(b_rdata), '1);
        else begin
          mon_r = exp_rd_b.pop_front();
          chk("b_rdata", 67'(b_rdata), 67'(mon_r));
        end
      end
      b_prev_stall = b_stall;
    end
  end

  // ---------------- driver tasks ----------------
  // Each cycle task checks the combinational outputs at the falling edge,
  // then advances to just after the next rising edge.
  task automatic cyc_a(input string tag, input logic er, input logic es);
    @(negedge clk);
    chk({tag, "_req"}, 67'(bus_a.req), 67'(er));
    chk({tag, "_stall"}, 67'(a_stall), 67'(es));
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input string tag, input logic er, input logic es);
    @(negedge clk);
    chk({tag, "_req"}, 67'(bus_b.req), 67'(er));
    chk({tag, "_stall"}, 67'(b_stall), 67'(es));
    @(posedge clk); #1;
  endtask

  // Minimum-latency access on A: addr_ok at once, data_ok next cycle.
  task automatic quick_a(input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wdata, input logic [31:0] rd,
                         input logic [1:0] exp_size, input logic [31:0] exp_addr);
    a_en = 1'b1; a_addr = addr; a_wen = wen; a_wdata = wdata;
    bus_a.addr_ok = 1'b1;
    exp_bus_a.push_back({(wen != 4'b0), exp_size, exp_addr, wdata});
    exp_rd_a.push_back(rd);
    cyc_a("qa_c0", 1'b1, 1'b1);
    bus_a.addr_ok = 1'b0; bus_a.data_ok = 1'b1; bus_a.rdata = rd;
    cyc_a("qa_c1", 1'b0, 1'b1);
    bus_a.data_ok = 1'b0;
    cyc_a("qa_c2", 1'b0, 1'b0);
    a_en = 1'b0; a_wen = 4'b0; a_wdata = 32'h0;
    cyc_a("qa_c3", 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] tbl_addr [7];
  logic [3:0]  tbl_wen  [7];
  logic [1:0]  tbl_size [7];
  logic [31:0] tbl_eaddr[7];

  initial begin
    tbl_addr[0] = 32'h0000_0100; tbl_wen[0] = 4'b0011; tbl_size[0] = 2'd1; tbl_eaddr[0] = 32'h0000_0100;
    tbl_addr[1] = 32'h0000_0103; tbl_wen[1] = 4'b1100; tbl_size[1] = 2'd1; tbl_eaddr[1] = 32'h0000_0102;
    tbl_addr[2] = 32'h0000_0102; tbl_wen[2] = 4'b1111; tbl_size[2] = 2'd2; tbl_eaddr[2] = 32'h0000_0100;
    tbl_addr[3] = 32'h0000_0100; tbl_wen[3] = 4'b1000; tbl_size[3] = 2'd0; tbl_eaddr[3] = 32'h0000_0103;
    tbl_addr[4] = 32'h0000_0101; tbl_wen[4] = 4'b0010; tbl_size[4] = 2'd0; tbl_eaddr[4] = 32'h0000_0101;
    tbl_addr[5] = 32'h0000_0101; tbl_wen[5] = 4'b0101; tbl_size[5] = 2'd2; tbl_eaddr[5] = 32'h0000_0100;
    tbl_addr[6] = 32'h0000_010F; tbl_wen[6] = 4'b0000; tbl_size[6] = 2'd2; tbl_eaddr[6] = 32'h0000_010C;

    rst = 1'b1;
    a_en = 1'b1; a_addr = 32'h0; a_wen = 4'b0; a_wdata = 32'h0; a_lstall = 1'b0; a_flush = 1'b0;
    b_en = 1'b0; b_addr = 32'h0; b_wen = 4'b0; b_wdata = 32'h0; b_lstall = 1'b0; b_flush = 1'b0;
    bus_a.addr_ok = 1'b0; bus_a.data_ok = 1'b0; bus_a.rdata = 32'h0;
    bus_b.addr_ok = 1'b0; bus_b.data_ok = 1'b0; bus_b.rdata = 32'h0;

    // Reset state: stall follows sram_en, no request, cleared data.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", 67'(a_stall), 67'(1));
    chk("rst_req", 67'(bus_a.req), 67'(0));
    chk("rst_rdata_a", 67'(a_rdata), 67'(0));
    chk("rst_rdata_b", 67'(b_rdata), 67'(0));
    chk("rst_state", 67'(a_dbg), 67'(S_IDLE));
    @(posedge clk); #1;
    a_en = 1'b0; rst = 1'b0;
    cyc_a("idle", 1'b0, 1'b0);

    // Read, addr_ok in cycle 0, data_ok in cycle 3.
    a_en = 1'b1; a_addr = 32'hBFC0_0004; bus_a.addr_ok = 1'b1;
    exp_bus_a.push_back({1'b0, 2'd2, 32'hBFC0_0004, 32'h0});
    exp_rd_a.push_back(32'h3C08_BFB0);
    cyc_a("t1_c0", 1'b1, 1'b1);
    bus_a.addr_ok = 1'b0;
    cyc_a("t1_c1", 1'b0, 1'b1);
    cyc_a("t1_c2", 1'b0, 1'b1);
    bus_a.data_ok = 1'b1; bus_a.rdata = 32'h3C08_BFB0;
    cyc_a("t1_c3", 1'b0, 1'b1);
    bus_a.data_ok = 1'b0; bus_a.rdata = 32'h0;
    chk("t1_rdata_c4", 67'(a_rdata), 67'(32'h3C08_BFB0));
    cyc_a("t1_c4", 1'b0, 1'b0);
    a_en = 1'b0;
    cyc_a("t1_c5", 1'b0, 1'b0);

    // Completed read held through 5 cycles of longest_stall.
    a_en = 1'b1; a_addr = 32'h0000_0010; a_lstall = 1'b1; bus_a.addr_ok = 1'b1;
    exp_bus_a.push_back({1'b0, 2'd2, 32'h0000_0010, 32'h0});
    exp_rd_a.push_back(32'h1111_2222);
    cyc_a("t2_c0", 1'b1, 1'b1);
    bus_a.addr_ok = 1'b0; bus_a.data_ok = 1'b1; bus_a.rdata = 32'h1111_2222;
    cyc_a("t2_c1", 1'b0, 1'b1);
    bus_a.data_ok = 1'b0; bus_a.rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_rdata", 67'(a_rdata), 67'(32'h1111_2222));
      chk("t2_hold_state", 67'(a_dbg), 67'(S_DONE));
      cyc_a("t2_done", 1'b0, 1'b0);
    end
    a_lstall = 1'b0;
    cyc_a("t2_release", 1'b0, 1'b0);
    a_en = 1'b0;
    cyc_a("t2_idle", 1'b0, 1'b0);
    chk("t2_idle_state", 67'(a_dbg), 67'(S_IDLE));
    chk("t2_idle_rdata", 67'(a_rdata), 67'(32'h1111_2222));

    // Byte write wen=0100 at 0x80000001, addr_ok delayed one cycle.
    a_en = 1'b1; a_addr = 32'h8000_0001; a_wen = 4'b0100; a_wdata = 32'h00AB_0000;
    #1;
    chk("t3_size", 67'(bus_a.size), 67'(0));
    chk("t3_addr", 67'(bus_a.addr), 67'(32'h8000_0002));
    chk("t3_wr", 67'(bus_a.wr), 67'(1));
    cyc_a("t3_c0", 1'b1, 1'b1);
    chk("t3_state_addr", 67'(a_dbg), 67'(S_ADDR));
    bus_a.addr_ok = 1'b1;
    exp_bus_a.push_back({1'b1, 2'd0, 32'h8000_0002, 32'h00AB_0000});
    exp_rd_a.push_back(32'h0);
    cyc_a("t3_c1", 1'b1, 1'b1);
    bus_a.addr_ok = 1'b0; bus_a.data_ok = 1'b1; bus_a.rdata = 32'h0;
    cyc_a("t3_c2", 1'b0, 1'b1);
    bus_a.data_ok = 1'b0;
    cyc_a("t3_c3", 1'b0, 1'b0);
    a_en = 1'b0; a_wen = 4'b0; a_wdata = 32'h0;
    cyc_a("t3_c4", 1'b0, 1'b0);

    // Strobe table: halfword, byte, word, illegal and read encodings.
    for (int i = 0; i < 7; i++)
      quick_a(tbl_addr[i], tbl_wen[i], 32'h1234_0000 | i, 32'hA5A5_0000 | i, tbl_size[i], tbl_eaddr[i]);

    // Flush in DATA; new read; stale 0xDEAD is dropped, 0x1234 is taken.
    a_en = 1'b1; a_addr = 32'h0000_0040; bus_a.addr_ok = 1'b1;
    exp_bus_a.push_back({1'b0, 2'd2, 32'h0000_0040, 32'h0});
    cyc_a("t4_c0", 1'b1, 1'b1);
    bus_a.addr_ok = 1'b0; a_flush = 1'b1;
    cyc_a("t4_c1", 1'b0, 1'b0);
    a_flush = 1'b0; a_addr = 32'h0000_0080; bus_a.addr_ok = 1'b1;
    exp_bus_a.push_back({1'b0, 2'd2, 32'h0000_0080, 32'h0});
    exp_rd_a.push_back(32'h0000_1234);
    cyc_a("t4_c2", 1'b1, 1'b1);
    bus_a.addr_ok = 1'b0; bus_a.data_ok = 1'b1; bus_a.rdata = 32'h0000_DEAD;
    cyc_a("t4_c3", 1'b0, 1'b1);
    chk("t4_state_after_stale", 67'(a_dbg), 67'(S_DATA));
    bus_a.rdata = 32'h0000_1234;
    cyc_a("t4_c4", 1'b0, 1'b1);
    bus_a.data_ok = 1'b0; bus_a.rdata = 32'h0;
    chk("t4_rdata", 67'(a_rdata), 67'(32'h0000_1234));
    cyc_a("t4_c5", 1'b0, 1'b0);
    a_en = 1'b0;
    cyc_a("t4_c6", 1'b0, 1'b0);

    // Flush alongside addr_ok: no handshake, back to IDLE.
    a_en = 1'b1; a_addr = 32'h0000_0300; a_flush = 1'b1; bus_a.addr_ok = 1'b1;
    cyc_a("t5_c0", 1'b0, 1'b0);
    a_en = 1'b0; a_flush = 1'b0; bus_a.addr_ok = 1'b0;
    cyc_a("t5_c1", 1'b0, 1'b0);
    chk("t5_state", 67'(a_dbg), 67'(S_IDLE));

    // DUT B: write attempt on a read-only port becomes a word read.
    b_en = 1'b1; b_addr = 32'h8000_0001; b_wen = 4'b0100; b_wdata = 32'hFFFF_FFFF;
    bus_b.addr_ok = 1'b1;
    exp_bus_b.push_back({1'b0, 2'd2, 32'h8000_0000, 32'h0});
    exp_rd_b.push_back(32'hCAFE_0001);
    cyc_b("b1_c0", 1'b1, 1'b1);
    bus_b.addr_ok = 1'b0; bus_b.data_ok = 1'b1; bus_b.rdata = 32'hCAFE_0001;
    cyc_b("b1_c1", 1'b0, 1'b1);
    bus_b.data_ok = 1'b0; bus_b.rdata = 32'h0;
    cyc_b("b1_c2", 1'b0, 1'b0);
    b_en = 1'b0; b_wen = 4'b0; b_wdata = 32'h0;
    cyc_b("b1_c3", 1'b0, 1'b0);

    // DUT B: read data visible for exactly one cycle after completion.
    b_en = 1'b1; b_addr = 32'h0000_0044; b_lstall = 1'b1; bus_b.addr_ok = 1'b1;
    exp_bus_b.push_back({1'b0, 2'd2, 32'h0000_0044, 32'h0});
    exp_rd_b.push_back(32'h7777_8888);
    cyc_b("b2_c0", 1'b1, 1'b1);
    bus_b.addr_ok = 1'b0; bus_b.data_ok = 1'b1; bus_b.rdata = 32'h7777_8888;
    cyc_b("b2_c1", 1'b0, 1'b1);
    bus_b.data_ok = 1'b0; bus_b.rdata = 32'h0;
    chk("b2_rdata_pulse", 67'(b_rdata), 67'(32'h7777_8888));
    cyc_b("b2_c2", 1'b0, 1'b0);
    chk("b2_rdata_cleared", 67'(b_rdata), 67'(0));
    cyc_b("b2_c3", 1'b0, 1'b0);
    b_lstall = 1'b0;
    cyc_b("b2_c4", 1'b0, 1'b0);
    b_en = 1'b0;
    cyc_b("b2_c5", 1'b0, 1'b0);

    // DUT B: two flushed reads saturate MAX_PEND=2.
    b_en = 1'b1; b_addr = 32'h0000_0200; bus_b.addr_ok = 1'b1;
    exp_bus_b.push_back({1'b0, 2'd2, 32'h0000_0200, 32'h0});
    cyc_b("sat_c0", 1'b1, 1'b1);
    bus_b.addr_ok = 1'b0; b_flush = 1'b1;
    cyc_b("sat_c1", 1'b0, 1'b0);
    b_flush = 1'b0; b_addr = 32'h0000_0204; bus_b.addr_ok = 1'b1;
    exp_bus_b.push_back({1'b0, 2'd2, 32'h0000_0204, 32'h0});
    cyc_b("sat_c2", 1'b1, 1'b1);
    bus_b.addr_ok = 1'b0; b_flush = 1'b1;
    cyc_b("sat_c3", 1'b0, 1'b0);
    b_flush = 1'b0; b_addr = 32'h0000_0208; bus_b.addr_ok = 1'b1;
    cyc_b("sat_c4", 1'b0, 1'b1);
    cyc_b("sat_c5", 1'b0, 1'b1);
    bus_b.data_ok = 1'b1; bus_b.rdata = 32'hDEAD_0001;
    cyc_b("sat_c6", 1'b0, 1'b1);
    bus_b.data_ok = 1'b0;
    exp_bus_b.push_back({1'b0, 2'd2, 32'h0000_0208, 32'h0});
    exp_rd_b.push_back(32'h0000_5555);
    cyc_b("sat_c7", 1'b1, 1'b1);
    bus_b.addr_ok = 1'b0; bus_b.data_ok = 1'b1; bus_b.rdata = 32'hDEAD_0002;
    cyc_b("sat_c8", 1'b0, 1'b1);
    bus_b.rdata = 32'h0000_5555;
    cyc_b("sat_c9", 1'b0, 1'b1);
    bus_b.data_ok = 1'b0; bus_b.rdata = 32'h0;
    chk("sat_rdata", 67'(b_rdata), 67'(32'h0000_5555));
    cyc_b("sat_c10", 1'b0, 1'b0);
    b_en = 1'b0;
    cyc_b("sat_c11", 1'b0, 1'b0);
    chk("sat_rdata_cleared", 67'(b_rdata), 67'(0));
    chk("sat_state", 67'(b_dbg), 67'(S_IDLE));

    // Everything pushed must have been seen.
    repeat (2) @(posedge clk);
    chk("a_bus_q_empty", 67'(exp_bus_a.size()), 67'(0));
    chk("a_rd_q_empty", 67'(exp_rd_a.size()), 67'(0));
    chk("b_bus_q_empty", 67'(exp_bus_b.size()), 67'(0));
    chk("b_rd_q_empty", 67'(exp_rd_b.size()), 67'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
